// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: control-word fields seen by the hazard unit and
// the MEM-stage data-memory access states.
package lc3b_types;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ACC1 = 2'd1,
        D_ACC2 = 2'd2,
        D_DONE = 2'd3
    } lc3b_dmem_state;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic indirect;
        logic br_taken;
    } lc3b_control_word;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } lc3b_stage_load;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
    } lc3b_stage_flush;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> hazard controller signal bundle. The datapath is the master
// (supplies ctrl words and memory responses); the controller is the slave.
interface pipeline_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic             imem_resp;
    logic             dmem_resp;
    logic             exm_mem_read;
    logic             exm_mem_write;
    logic             exm_indirect;
    logic             exm_br_taken;
    logic             idex_mem_read;
    logic [REG_W-1:0] idex_dest;
    logic [REG_W-1:0] ifid_src1;
    logic [REG_W-1:0] ifid_src2;
    logic             ifid_use_src1;
    logic             ifid_use_src2;

    logic             load_pc;
    logic             load_if_id;
    logic             load_id_ex;
    logic             load_ex_mem;
    logic             load_mem_wb;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic             pc_sel_br;
    logic             imem_read;
    logic             dmem_read;
    logic             dmem_write;
    logic             mar_load_indirect;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output imem_resp, dmem_resp, exm_mem_read, exm_mem_write, exm_indirect,
               exm_br_taken, idex_mem_read, idex_dest, ifid_src1, ifid_src2,
               ifid_use_src1, ifid_use_src2,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_br, imem_read,
               dmem_read, dmem_write, mar_load_indirect, stall_count
    );

    modport slave (
        input  imem_resp, dmem_resp, exm_mem_read, exm_mem_write, exm_indirect,
               exm_br_taken, idex_mem_read, idex_dest, ifid_src1, ifid_src2,
               ifid_use_src1, ifid_use_src2,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_br, imem_read,
               dmem_read, dmem_write, mar_load_indirect, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl_dmem_fsm.sv
// MEM-stage data-memory access sequencer. Indirect ops (LDI/STI) take two
// accesses: the first always reads the pointer, the second does the real op.
module dmem_fsm
    import lc3b_types::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_mem_read,
    input  logic i_mem_write,
    input  logic i_indirect,
    input  logic i_dmem_resp,
    output logic o_dmem_stall,
    output logic o_dmem_read,
    output logic o_dmem_write,
    output logic o_mar_load_indirect
);

    lc3b_dmem_state r_state;
    lc3b_dmem_state w_next;
    logic           w_need;

    assign w_need = i_mem_read | i_mem_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= D_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next              = r_state;
        o_dmem_stall        = 1'b0;
        o_dmem_read         = 1'b0;
        o_dmem_write        = 1'b0;
        o_mar_load_indirect = 1'b0;
        case (r_state)
            D_IDLE: begin
                if (w_need) begin
                    w_next       = D_ACC1;
                    o_dmem_stall = 1'b1;
                end
            end
            D_ACC1: begin
                o_dmem_read  = i_mem_read | i_indirect;
                o_dmem_write = i_mem_write & ~i_indirect;
                o_dmem_stall = 1'b1;
                if (i_dmem_resp) begin
                    if (i_indirect) begin
                        o_mar_load_indirect = 1'b1;
                        w_next              = D_ACC2;
                    end else begin
                        o_dmem_stall = 1'b0;
                        w_next       = D_DONE;
                    end
                end
            end
            D_ACC2: begin
                o_dmem_read  = i_mem_read;
                o_dmem_write = i_mem_write;
                o_dmem_stall = 1'b1;
                if (i_dmem_resp) begin
                    o_dmem_stall = 1'b0;
                    w_next       = D_DONE;
                end
            end
            // One settle cycle so the instruction that just advanced into
            // EX/MEM is not mistaken for the one already serviced.
            D_DONE:  w_next = D_IDLE;
            default: w_next = D_IDLE;
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// LC-3b 5-stage hazard/stall controller: stage enables, flushes, PC select,
// load-use bubbles, branch squash and a saturating stall-cycle counter.
module pipeline_ctrl
    import lc3b_types::*;
#(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    pipeline_ctrl_if.slave  bus
);

    lc3b_control_word w_exm;
    lc3b_stage_load   w_load;
    lc3b_stage_flush  w_flush;
    logic [REG_W-1:0] w_dest;
    logic             w_pc_sel_br;
    logic             w_imem_stall;
    logic             w_dmem_stall;
    logic             w_dmem_read;
    logic             w_dmem_write;
    logic             w_mar_ld;
    logic             w_luh;
    logic             w_stall_cycle;
    logic [CNT_W-1:0] r_stall_count;

    assign w_exm = '{mem_read:  bus.exm_mem_read,
                     mem_write: bus.exm_mem_write,
                     indirect:  bus.exm_indirect,
                     br_taken:  bus.exm_br_taken};

    assign w_dest       = bus.idex_dest;
    assign w_imem_stall = ~bus.imem_resp;
    assign w_luh = bus.idex_mem_read &
                   ((bus.ifid_use_src1 & (bus.ifid_src1 == w_dest)) |
                    (bus.ifid_use_src2 & (bus.ifid_src2 == w_dest)));

    dmem_fsm u_dmem_fsm (
        .clk                 (clk),
        .reset               (reset),
        .i_mem_read          (w_exm.mem_read),
        .i_mem_write         (w_exm.mem_write),
        .i_indirect          (w_exm.indirect),
        .i_dmem_resp         (bus.dmem_resp),
        .o_dmem_stall        (w_dmem_stall),
        .o_dmem_read         (w_dmem_read),
        .o_dmem_write        (w_dmem_write),
        .o_mar_load_indirect (w_mar_ld)
    );

    // Frozen pipeline beats branch; branch beats load-use because the
    // dependent instruction is on the wrong path and gets squashed anyway.
    always_comb begin
        w_load        = '0;
        w_flush       = '0;
        w_pc_sel_br   = 1'b0;
        w_stall_cycle = 1'b0;
        if (!reset) begin
            if (w_dmem_stall | w_imem_stall) begin
                w_stall_cycle = 1'b1;
            end else if (w_exm.br_taken) begin
                w_load      = '1;
                w_flush     = '1;
                w_pc_sel_br = 1'b1;
            end else if (w_luh) begin
                w_load        = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b1,
                                  ex_mem: 1'b1, mem_wb: 1'b1};
                w_flush.id_ex = 1'b1;
                w_stall_cycle = 1'b1;
            end else begin
                w_load = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_count <= '0;
        else if (w_stall_cycle && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.load_pc           = w_load.pc;
    assign bus.load_if_id        = w_load.if_id;
    assign bus.load_id_ex        = w_load.id_ex;
    assign bus.load_ex_mem       = w_load.ex_mem;
    assign bus.load_mem_wb       = w_load.mem_wb;
    assign bus.flush_if_id       = w_flush.if_id;
    assign bus.flush_id_ex       = w_flush.id_ex;
    assign bus.flush_ex_mem      = w_flush.ex_mem;
    assign bus.pc_sel_br         = w_pc_sel_br;
    assign bus.imem_read         = ~reset;
    assign bus.dmem_read         = w_dmem_read & ~reset;
    assign bus.dmem_write        = w_dmem_write & ~reset;
    assign bus.mar_load_indirect = w_mar_ld & ~reset;
    assign bus.stall_count       = r_stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl; a second narrow-counter
// instance shares the stimulus to exercise counter saturation.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.REG_W(3), .CNT_W(16)) ifc ();
    pipeline_ctrl_if #(.REG_W(3), .CNT_W(3))  ifs ();

    pipeline_ctrl #(.REG_W(3), .CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(ifc.slave));
    pipeline_ctrl #(.REG_W(3), .CNT_W(3))  dut_s (.clk(clk), .reset(reset), .bus(ifs.slave));

    assign ifs.imem_resp     = ifc.imem_resp;
    assign ifs.dmem_resp     = ifc.dmem_resp;
    assign ifs.exm_mem_read  = ifc.exm_mem_read;
    assign ifs.exm_mem_write = ifc.exm_mem_write;
    assign ifs.exm_indirect  = ifc.exm_indirect;
    assign ifs.exm_br_taken  = ifc.exm_br_taken;
    assign ifs.idex_mem_read = ifc.idex_mem_read;
    assign ifs.idex_dest     = ifc.idex_dest;
    assign ifs.ifid_src1     = ifc.ifid_src1;
    assign ifs.ifid_src2     = ifc.ifid_src2;
    assign ifs.ifid_use_src1 = ifc.ifid_use_src1;
    assign ifs.ifid_use_src2 = ifc.ifid_use_src2;

    typedef struct {
        int          id;
        logic [12:0] ctl;   // {loads[4:0], flushes[2:0], sel, imem_rd, dmem_rd, dmem_wr, mar}
        logic [15:0] cnt;
        logic [2:0]  cnt_s;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_id = 0;

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] NON = 5'b00000;
    localparam logic [4:0] LUH = 5'b00111;

    task automatic tick(input logic rst_v);
        @(posedge clk);
        #1;
        reset  = rst_v;
        cyc_id = cyc_id + 1;
    endtask

    task automatic drv(input logic imr, input logic dr, input logic mr, input logic mw,
                       input logic ind, input logic br, input logic xmr, input logic [2:0] dest,
                       input logic [2:0] s1, input logic [2:0] s2, input logic u1, input logic u2);
        ifc.imem_resp     = imr;
        ifc.dmem_resp     = dr;
        ifc.exm_mem_read  = mr;
        ifc.exm_mem_write = mw;
        ifc.exm_indirect  = ind;
        ifc.exm_br_taken  = br;
        ifc.idex_mem_read = xmr;
        ifc.idex_dest     = dest;
        ifc.ifid_src1     = s1;
        ifc.ifid_src2     = s2;
        ifc.ifid_use_src1 = u1;
        ifc.ifid_use_src2 = u2;
    endtask

    task automatic expect_out(input logic [4:0] ld, input logic [2:0] fl, input logic sel,
                              input logic drd, input logic dwr, input logic mar, input int cnt);
        exp_t e;
        e.id    = cyc_id;
        e.ctl   = {ld, fl, sel, ~reset, drd, dwr, mar};
        e.cnt   = 16'(cnt);
        e.cnt_s = (cnt > 7) ? 3'd7 : 3'(cnt);
        q.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [12:0] act;
            e   = q.pop_front();
            act = {ifc.load_pc, ifc.load_if_id, ifc.load_id_ex, ifc.load_ex_mem, ifc.load_mem_wb,
                   ifc.flush_if_id, ifc.flush_id_ex, ifc.flush_ex_mem, ifc.pc_sel_br,
                   ifc.imem_read, ifc.dmem_read, ifc.dmem_write, ifc.mar_load_indirect};
            total = total + 1;
            if (act !== e.ctl) begin
                bad = bad + 1;
                $display("FAIL ctl cyc=%0d got=%b want=%b", e.id, act, e.ctl);
            end
            total = total + 1;
            if (ifc.stall_count !== e.cnt) begin
                bad = bad + 1;
                $display("FAIL stall_count cyc=%0d got=%0d want=%0d", e.id, ifc.stall_count, e.cnt);
            end
            total = total + 1;
            if (ifs.stall_count !== e.cnt_s) begin
                bad = bad + 1;
                $display("FAIL sat_count cyc=%0d got=%0d want=%0d", e.id, ifs.stall_count, e.cnt_s);
            end
        end
    end

    initial begin
        drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        // reset held
        tick(1); drv(1,0,0,0,0,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 0);
        tick(0); drv(1,0,0,0,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,0,0, 0);
        // LDR: response on second D_ACC1 cycle
        tick(0); drv(1,0,1,0,0,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 0);
        tick(0); drv(1,0,1,0,0,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 1,0,0, 1);
        tick(0); drv(1,1,1,0,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 1,0,0, 2);
        tick(0); drv(1,1,0,0,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,0,0, 2);
        tick(0); drv(1,1,0,0,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,0,0, 2);
        // STI: one wait per access
        tick(0); drv(1,0,0,1,1,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 2);
        tick(0); drv(1,0,0,1,1,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 1,0,0, 3);
        tick(0); drv(1,1,0,1,1,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 1,0,1, 4);
        tick(0); drv(1,0,0,1,1,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,1,0, 5);
        tick(0); drv(1,1,0,1,1,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,1,0, 6);
        tick(0); drv(1,0,0,1,1,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,0,0, 6);
        // only one D_DONE: a following STR starts a fresh access
        tick(0); drv(1,0,0,1,0,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 6);
        tick(0); drv(1,0,0,1,0,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,1,0, 7);
        tick(0); drv(1,1,0,1,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,1,0, 8);
        tick(0); drv(1,0,0,0,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,0,0, 8);
        // load-use hazards
        tick(0); drv(1,0,0,0,0,0, 1,3,1,3,1,1); expect_out(LUH,3'b010,0, 0,0,0, 8);
        tick(0); drv(1,0,0,0,0,0, 1,3,1,3,1,0); expect_out(ALL,3'b000,0, 0,0,0, 9);
        tick(0); drv(1,0,0,0,0,0, 1,3,3,2,1,0); expect_out(LUH,3'b010,0, 0,0,0, 9);
        tick(0); drv(1,0,0,0,0,0, 0,3,3,3,1,1); expect_out(ALL,3'b000,0, 0,0,0, 10);
        // branch wins over load-use
        tick(0); drv(1,0,0,0,0,1, 1,3,1,3,1,1); expect_out(ALL,3'b111,1, 0,0,0, 10);
        // branch held during imem stall, squash on first unstalled cycle
        tick(0); drv(0,0,0,0,0,1, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 10);
        tick(0); drv(0,0,0,0,0,1, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 11);
        tick(0); drv(1,0,0,0,0,1, 0,0,1,2,0,0); expect_out(ALL,3'b111,1, 0,0,0, 12);
        tick(0); drv(1,0,0,0,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,0,0, 12);
        // LDI into D_ACC2, then reset mid-access
        tick(0); drv(1,0,1,0,1,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 12);
        tick(0); drv(1,1,1,0,1,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 1,0,1, 13);
        tick(0); drv(1,0,1,0,1,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 1,0,0, 14);
        tick(1); drv(1,0,1,0,1,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 0);
        tick(0); drv(1,0,1,0,1,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 0);
        tick(0); drv(1,1,1,0,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 1,0,0, 1);
        tick(0); drv(1,0,0,0,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,0,0, 1);
        // long imem stall drives the narrow counter into saturation
        for (int i = 0; i < 10; i++) begin
            tick(0); drv(0,0,0,0,0,0, 0,0,1,2,0,0); expect_out(NON,3'b000,0, 0,0,0, 1 + i);
        end
        tick(0); drv(1,0,0,0,0,0, 0,0,1,2,0,0); expect_out(ALL,3'b000,0, 0,0,0, 11);

        for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
        #2;
        if (q.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Sequential hazard/stall controller for the 5-stage LC-3b pipeline. It drives the load and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage buffers and the PC load. It runs the data-memory access FSM for the MEM stage, including the two-access LDI/STI sequence. It inserts bubbles for load-use hazards and squashes wrong-path instructions on a taken branch.

Parameters:
REG_W, 3, register-specifier width.
CNT_W, 16, stall-cycle counter width.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
imem_resp  in  1  instruction memory read complete this cycle.
dmem_resp  in  1  data memory access complete this cycle.
exm_mem_read  in  1  EX/MEM ctrl word: instruction reads memory (LDR/LDB/LDI).
exm_mem_write  in  1  EX/MEM ctrl word: instruction writes memory (STR/STB/STI).
exm_indirect  in  1  EX/MEM ctrl word: LDI/STI.
exm_br_taken  in  1  branch/jump resolved taken in MEM stage.
idex_mem_read  in  1  ID/EX ctrl word: instruction is a load.
idex_dest  in  REG_W  ID/EX destination register.
ifid_src1, ifid_src2  in  REG_W  IF/ID source registers.
ifid_use_src1, ifid_use_src2  in  1  IF/ID source operand is actually read.
load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  stage enables.
flush_if_id, flush_id_ex, flush_ex_mem  out  1  load a NOP control word into the buffer.
pc_sel_br  out  1  PC mux selects the branch target.
imem_read  out  1  instruction fetch request.
dmem_read, dmem_write  out  1  data memory request.
mar_load_indirect  out  1  one-cycle pulse: load MAR from MDR (end of first indirect access).
stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, any state): FSM to D_IDLE; stall_count=0; all outputs 0 while reset is high.
- imem_read is 1 whenever reset is low. imem_stall = !imem_resp.
- dmem_need = exm_mem_read | exm_mem_write.
- Data FSM states:
  - D_IDLE: if dmem_need, go to D_ACC1. dmem_stall=1 in this cycle.
  - D_ACC1: dmem_read = exm_mem_read | exm_indirect; dmem_write = exm_mem_write & !exm_indirect.
    - On dmem_resp with exm_indirect: pulse mar_load_indirect, go to D_ACC2, stall stays 1.
    - On dmem_resp without exm_indirect: go to D_DONE, stall=0 this cycle.
  - D_ACC2: dmem_read = exm_mem_read; dmem_write = exm_mem_write. On dmem_resp go to D_DONE, stall=0 this cycle.
  - D_DONE: one cycle, dmem_stall=0. Go to D_IDLE. This keeps the just-advanced instruction from re-triggering.
- dmem_resp is ignored in D_IDLE and D_DONE.
- Minimum memory-op cost: 1 extra cycle; indirect ops need ≥2 responses.
- Load-use hazard: luh = idex_mem_read & ((ifid_use_src1 & ifid_src1==idex_dest) | (ifid_use_src2 & ifid_src2==idex_dest)).
- Priority each cycle (highest first):
  1. dmem_stall | imem_stall: all load_* = 0, all flush_* = 0. Pipeline frozen, so exm_br_taken is held stable.
  2. exm_br_taken: all loads = 1; pc_sel_br = 1; flush_if_id = flush_id_ex = flush_ex_mem = 1. A load-use hazard in the same cycle is ignored, because the squashed instruction is discarded.
  3. luh: load_pc = load_if_id = 0; flush_id_ex = 1; load_id_ex = load_ex_mem = load_mem_wb = 1.
  4. Otherwise all loads = 1, all flushes = 0, pc_sel_br = 0.
- A flush is only meaningful with its load high. The block never asserts flush_x with load_x = 0.
- stall_count increments on each cycle with priority case 1 or 3. It saturates at all-ones and never wraps.
- All outputs are combinational from state and inputs, except stall_count and the FSM state, which are registered.

Decomposition:
- Package lc3b_types gains the enum lc3b_dmem_state {D_IDLE, D_ACC1, D_ACC2, D_DONE}.
- Ctrl-word fields mem_read, mem_write, indirect and br_taken come from the existing lc3b_control_word.
- One sub-module, dmem_fsm, holds the data-memory state machine and outputs dmem_stall, dmem_read, dmem_write and mar_load_indirect.
- Hazard priority logic and stall_count live in pipeline_ctrl.

Test Plan:
- LDR with dmem_resp on the 2nd cycle of D_ACC1 → loads 0 for 2 cycles; dmem_read=1 for 2 cycles; then D_DONE with all loads 1; stall_count=2.
- STI with dmem_resp each access after 1 wait → D_ACC1: dmem_read=1; mar_load_indirect pulses once. D_ACC2: dmem_write=1, dmem_read=0. Exactly one D_DONE.
- LDR R3 in ID/EX, ADD using R3 as src2 in IF/ID → one cycle with load_pc=0, load_if_id=0, flush_id_ex=1; stall_count +1. Same with ifid_use_src2=0 → no stall.
- exm_br_taken=1 together with luh=1 → pc_sel_br=1; three flushes=1; all loads=1; stall_count unchanged.
- exm_br_taken during imem_stall → no flush until imem_resp, then flush on the first unstalled cycle.
- Reset asserted in D_ACC2 → FSM in D_IDLE immediately, all outputs 0. Force stall_count to 0xFFFE, stall 3 cycles → saturates at 0xFFFF.
